// File: rtl/rn_dispatch_ctrl_pkg.sv
// Shared types and defaults for the rename/dispatch control slice of the o3 core.
package o3_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_RECOVER = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_HALTED  = 2'd3
   } rn_state_e;

   localparam logic [1:0] FU_NONE = 2'd0;
   localparam logic [1:0] FU_ALU  = 2'd1;
   localparam logic [1:0] FU_MUL  = 2'd2;
   localparam logic [1:0] FU_LSU  = 2'd3;

   localparam int ROB_DEPTH_DEF   = 16;
   localparam int PREG_FREE_DEF   = 32;
   localparam int RS_DEPTH_DEF    = 8;
   localparam int CNT_W_DEF       = 6;
   localparam int RECOVER_CYC_DEF = 2;

endpackage

// File: rtl/rn_dispatch_ctrl_credit_counter.sv
// Saturating up/down credit counter bounded by [0, MAX]; err pulses when an update
// would leave that range, and load overrides inc/dec.
module credit_counter #(
   parameter int W   = 6,
   parameter int MAX = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         dec,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] cnt,
   output logic         err
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] cnt_q, cnt_d;

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_d = cnt_q;
      err   = 1'b0;
      if (load) begin
         if (load_val > MAX_V) begin
            cnt_d = MAX_V;
            err   = 1'b1;
         end else begin
            cnt_d = load_val;
         end
      end else if (inc && !dec) begin
         if (cnt_q == MAX_V) err = 1'b1;
         else                cnt_d = cnt_q + W'(1);
      end else if (dec && !inc) begin
         if (cnt_q == '0) err = 1'b1;
         else             cnt_d = cnt_q - W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= MAX_V;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/rn_dispatch_ctrl.sv
// ID->RN hand-off control: credit tracking for ROB/preg/RS, dispatch/stall/flush
// generation, and the mispredict-recovery and drain-to-halt sequences.
module rn_dispatch_ctrl
   import o3_pkg::*;
#(
   parameter int ROB_DEPTH   = ROB_DEPTH_DEF,
   parameter int PREG_FREE   = PREG_FREE_DEF,
   parameter int RS_DEPTH    = RS_DEPTH_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int RECOVER_CYC = RECOVER_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rn_valid,
   input  logic             rn_regwrite,
   input  logic             rn_needs_rs,
   input  logic             ext_stall,
   input  logic             rob_commit,
   input  logic             commit_free,
   input  logic             rs_release,
   input  logic             mispredict,
   input  logic [CNT_W-1:0] rst_rob_free,
   input  logic [CNT_W-1:0] rst_preg_free,
   input  logic [CNT_W-1:0] rst_rs_free,
   input  logic             halt_req,
   output logic             id_rn_en,
   output logic             id_rn_stall,
   output logic             id_rn_flush,
   output logic             if_id_stall,
   output logic             rn_dispatch,
   output logic [CNT_W-1:0] rob_free,
   output logic [CNT_W-1:0] preg_free,
   output logic [CNT_W-1:0] rs_free,
   output logic             halted,
   output logic             credit_err
);

   localparam int                RCNT_W    = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
   localparam logic [RCNT_W-1:0] RCNT_INIT = RCNT_W'(RECOVER_CYC - 1);
   localparam logic [CNT_W-1:0]  ROB_FULL  = CNT_W'(ROB_DEPTH);

   rn_state_e         state_q;
   logic [RCNT_W-1:0] rcnt_q;
   logic              credit_err_q, credit_err_d;
   logic              rob_err, preg_err, rs_err;
   logic              ok;

   assign ok = (rob_free != '0) && (!rn_regwrite || preg_free != '0)
            && (!rn_needs_rs || rs_free != '0);

   always_comb begin
      rn_dispatch = 1'b0;
      id_rn_stall = 1'b0;
      if_id_stall = 1'b0;
      id_rn_flush = mispredict;
      id_rn_en    = 1'b1;
      unique case (state_q)
         ST_RUN: begin
            rn_dispatch = rn_valid & ok & !ext_stall & !mispredict & !halt_req;
            id_rn_stall = rn_valid & !rn_dispatch & !mispredict;
            if_id_stall = id_rn_stall;
         end
         ST_RECOVER: id_rn_flush = 1'b1;
         ST_DRAIN, ST_HALTED: begin
            id_rn_stall = !mispredict;
            if_id_stall = !mispredict;
         end
         default: ;
      endcase
   end

   credit_counter #(.W(CNT_W), .MAX(ROB_DEPTH)) u_rob_cnt (
      .clk(clk), .rst_n(rst_n), .inc(rob_commit), .dec(rn_dispatch),
      .load(mispredict), .load_val(rst_rob_free), .cnt(rob_free), .err(rob_err)
   );

   credit_counter #(.W(CNT_W), .MAX(PREG_FREE)) u_preg_cnt (
      .clk(clk), .rst_n(rst_n), .inc(commit_free), .dec(rn_dispatch & rn_regwrite),
      .load(mispredict), .load_val(rst_preg_free), .cnt(preg_free), .err(preg_err)
   );

   credit_counter #(.W(CNT_W), .MAX(RS_DEPTH)) u_rs_cnt (
      .clk(clk), .rst_n(rst_n), .inc(rs_release), .dec(rn_dispatch & rn_needs_rs),
      .load(mispredict), .load_val(rst_rs_free), .cnt(rs_free), .err(rs_err)
   );

   assign credit_err_d = credit_err_q | rob_err | preg_err | rs_err;

   // Mispredict wins from any state and restarts the map-restore countdown.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_RUN;
         rcnt_q       <= '0;
         credit_err_q <= 1'b0;
      end else begin
         credit_err_q <= credit_err_d;
         if (mispredict) begin
            state_q <= ST_RECOVER;
            rcnt_q  <= RCNT_INIT;
         end else begin
            unique case (state_q)
               ST_RUN:     if (halt_req) state_q <= ST_DRAIN;
               ST_RECOVER: begin
                  if (rcnt_q == '0) state_q <= ST_RUN;
                  else              rcnt_q  <= rcnt_q - RCNT_W'(1);
               end
               ST_DRAIN: begin
                  if (!halt_req)              state_q <= ST_RUN;
                  else if (rob_free == ROB_FULL) state_q <= ST_HALTED;
               end
               ST_HALTED:  if (!halt_req) state_q <= ST_RUN;
               default:    state_q <= ST_RUN;
            endcase
         end
      end
   end

   assign halted     = (state_q == ST_HALTED);
   assign credit_err = credit_err_q;

endmodule

// File: tb/tb_rn_dispatch_ctrl.sv
// Directed bench for rn_dispatch_ctrl: expectations are queued as each step is driven
// and drained against the DUT at the following negedge.
module tb_rn_dispatch_ctrl;
   import o3_pkg::*;

   localparam int CNT_W = 6;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             rn_valid, rn_regwrite, rn_needs_rs, ext_stall;
   logic             rob_commit, commit_free, rs_release, mispredict, halt_req;
   logic [CNT_W-1:0] rst_rob_free, rst_preg_free, rst_rs_free;
   logic             id_rn_en, id_rn_stall, id_rn_flush, if_id_stall, rn_dispatch;
   logic [CNT_W-1:0] rob_free, preg_free, rs_free;
   logic             halted, credit_err;

   always #5 clk = ~clk;

   rn_dispatch_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .rn_valid(rn_valid), .rn_regwrite(rn_regwrite), .rn_needs_rs(rn_needs_rs),
      .ext_stall(ext_stall), .rob_commit(rob_commit), .commit_free(commit_free),
      .rs_release(rs_release), .mispredict(mispredict),
      .rst_rob_free(rst_rob_free), .rst_preg_free(rst_preg_free), .rst_rs_free(rst_rs_free),
      .halt_req(halt_req),
      .id_rn_en(id_rn_en), .id_rn_stall(id_rn_stall), .id_rn_flush(id_rn_flush),
      .if_id_stall(if_id_stall), .rn_dispatch(rn_dispatch),
      .rob_free(rob_free), .preg_free(preg_free), .rs_free(rs_free),
      .halted(halted), .credit_err(credit_err)
   );

   typedef enum int {S_EN, S_STALL, S_IFST, S_FLUSH, S_DISP, S_ROB, S_PREG, S_RS, S_HALT, S_ERR} sig_e;
   typedef struct {
      string tag;
      sig_e  sig;
      int    val;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   function automatic int get_sig(sig_e s);
      case (s)
         S_EN:    return int'(id_rn_en);
         S_STALL: return int'(id_rn_stall);
         S_IFST:  return int'(if_id_stall);
         S_FLUSH: return int'(id_rn_flush);
         S_DISP:  return int'(rn_dispatch);
         S_ROB:   return int'(rob_free);
         S_PREG:  return int'(preg_free);
         S_RS:    return int'(rs_free);
         S_HALT:  return int'(halted);
         S_ERR:   return int'(credit_err);
         default: return -1;
      endcase
   endfunction

   task automatic push(string tag, sig_e s, int v);
      exp_t e;
      e.tag = tag;
      e.sig = s;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic exp_ctrl(string tag, int disp, int stall, int flush);
      push({tag, ".en"},    S_EN,    1);
      push({tag, ".disp"},  S_DISP,  disp);
      push({tag, ".stall"}, S_STALL, stall);
      push({tag, ".ifst"},  S_IFST,  stall);
      push({tag, ".flush"}, S_FLUSH, flush);
   endtask

   task automatic exp_cred(string tag, int rob, int preg, int rs);
      push({tag, ".rob"},  S_ROB,  rob);
      push({tag, ".preg"}, S_PREG, preg);
      push({tag, ".rs"},   S_RS,   rs);
   endtask

   task automatic compare_all();
      exp_t e;
      int   obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = get_sig(e.sig);
         n_cmp++;
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rn_valid = 0; rn_regwrite = 0; rn_needs_rs = 0; ext_stall = 0;
      rob_commit = 0; commit_free = 0; rs_release = 0; mispredict = 0; halt_req = 0;
      rst_rob_free = '0; rst_preg_free = '0; rst_rs_free = '0;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      #12 rst_n = 1'b1;
      @(posedge clk);
      #1;

      exp_ctrl("reset", 0, 0, 0); exp_cred("reset", 16, 32, 8);
      push("reset.halt", S_HALT, 0); push("reset.err", S_ERR, 0);
      cyc();

      // Fill until RS credits run out.
      rn_valid = 1; rn_regwrite = 1; rn_needs_rs = 1;
      for (int i = 0; i < 8; i++) begin
         exp_ctrl("fill", 1, 0, 0); exp_cred("fill", 16 - i, 32 - i, 8 - i);
         cyc();
      end
      exp_ctrl("rs_empty", 0, 1, 0); exp_cred("rs_empty", 8, 24, 0);
      cyc();

      rs_release = 1;
      exp_ctrl("rel_same", 0, 1, 0); exp_cred("rel_same", 8, 24, 0);
      cyc();
      rs_release = 0;
      exp_ctrl("rel_after", 1, 0, 0); exp_cred("rel_after", 8, 24, 1);
      cyc();
      rn_valid = 0;
      exp_ctrl("idle", 0, 0, 0); exp_cred("idle", 7, 23, 0);
      cyc();

      // Single mispredict.
      rn_valid = 1; mispredict = 1;
      rst_rob_free = 6'd12; rst_preg_free = 6'd20; rst_rs_free = 6'd5;
      exp_ctrl("mp_T", 0, 0, 1); exp_cred("mp_T", 7, 23, 0);
      cyc();
      mispredict = 0;
      exp_ctrl("mp_T1", 0, 0, 1); exp_cred("mp_T1", 12, 20, 5);
      cyc();
      exp_ctrl("mp_T2", 0, 0, 1); exp_cred("mp_T2", 12, 20, 5);
      cyc();
      exp_ctrl("mp_T3", 1, 0, 0); exp_cred("mp_T3", 12, 20, 5);
      cyc();

      // Repeat mispredict one cycle into recovery.
      mispredict = 1;
      exp_ctrl("mp2_T", 0, 0, 1); exp_cred("mp2_T", 11, 19, 4);
      cyc();
      rst_rob_free = 6'd10; rst_preg_free = 6'd18; rst_rs_free = 6'd3;
      exp_ctrl("mp2_T1", 0, 0, 1); exp_cred("mp2_T1", 12, 20, 5);
      cyc();
      mispredict = 0;
      exp_ctrl("mp2_T2", 0, 0, 1); exp_cred("mp2_T2", 10, 18, 3);
      cyc();
      exp_ctrl("mp2_T3", 0, 0, 1);
      cyc();
      exp_ctrl("mp2_T4", 1, 0, 0); exp_cred("mp2_T4", 10, 18, 3);
      cyc();
      rn_valid = 0;
      exp_cred("mp2_T5", 9, 17, 2);
      cyc();

      // Set up 3 outstanding ROB entries, then drain and halt.
      mispredict = 1;
      rst_rob_free = 6'd13; rst_preg_free = 6'd29; rst_rs_free = 6'd5;
      exp_ctrl("mp3_T", 0, 0, 1);
      cyc();
      mispredict = 0;
      exp_ctrl("mp3_T1", 0, 0, 1);
      cyc();
      exp_ctrl("mp3_T2", 0, 0, 1);
      cyc();
      rn_valid = 1; rn_regwrite = 1; rn_needs_rs = 0; halt_req = 1;
      exp_ctrl("halt_req", 0, 1, 0); exp_cred("halt_req", 13, 29, 5);
      push("halt_req.halt", S_HALT, 0);
      cyc();
      rob_commit = 1;
      for (int i = 0; i < 3; i++) begin
         exp_ctrl("drain", 0, 1, 0); push("drain.rob", S_ROB, 13 + i);
         push("drain.halt", S_HALT, 0);
         cyc();
      end
      rob_commit = 0;
      exp_ctrl("drain_full", 0, 1, 0); push("drain_full.rob", S_ROB, 16);
      push("drain_full.halt", S_HALT, 0);
      cyc();
      exp_ctrl("halted", 0, 1, 0); push("halted.halt", S_HALT, 1);
      cyc();
      halt_req = 0;
      exp_ctrl("halt_drop", 0, 1, 0); push("halt_drop.halt", S_HALT, 1);
      cyc();
      exp_ctrl("resume", 1, 0, 0); exp_cred("resume", 16, 29, 5);
      push("resume.halt", S_HALT, 0);
      cyc();

      // ROB credit overflow, sticky error, then async reset mid-recovery.
      rn_valid = 0; rob_commit = 1;
      push("ovf0.rob", S_ROB, 15); push("ovf0.preg", S_PREG, 28); push("ovf0.err", S_ERR, 0);
      cyc();
      push("ovf1.rob", S_ROB, 16); push("ovf1.err", S_ERR, 0);
      cyc();
      rob_commit = 0;
      push("ovf2.rob", S_ROB, 16); push("ovf2.err", S_ERR, 1);
      cyc();
      push("ovf3.rob", S_ROB, 16); push("ovf3.err", S_ERR, 1);
      cyc();
      mispredict = 1;
      rst_rob_free = 6'd4; rst_preg_free = 6'd4; rst_rs_free = 6'd4;
      exp_ctrl("mp4_T", 0, 0, 1);
      cyc();
      mispredict = 0;
      exp_ctrl("mp4_T1", 0, 0, 1); exp_cred("mp4_T1", 4, 4, 4); push("mp4_T1.err", S_ERR, 1);
      cyc();
      #1 rst_n = 1'b0;
      #1;
      exp_ctrl("async_rst", 0, 0, 0); exp_cred("async_rst", 16, 32, 8);
      push("async_rst.err", S_ERR, 0); push("async_rst.halt", S_HALT, 0);
      compare_all();
      #1 rst_n = 1'b1;
      exp_ctrl("post_rst", 0, 0, 0); exp_cred("post_rst", 16, 32, 8);
      cyc();
      rn_valid = 1; rn_regwrite = 1; rn_needs_rs = 1;
      exp_ctrl("post_rst_disp", 1, 0, 0);
      cyc();
      rn_valid = 0;
      exp_cred("post_rst_after", 15, 31, 7);
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
